// File: rtl/snake_motion_ctrl_if.sv
// snake_motion_ctrl_if: direction/pause requests in, per-segment coordinates and game status out.
interface snake_motion_ctrl_if #(
    parameter int SEG_MAX = 12
);
    logic                  iKEY_UP;
    logic                  iKEY_DOWN;
    logic                  iKEY_LEFT;
    logic                  iKEY_RIGHT;
    logic                  iPAUSE;
    logic [10*SEG_MAX-1:0] oSEG_X;
    logic [10*SEG_MAX-1:0] oSEG_Y;
    logic [3:0]            oLen;
    logic [1:0]            oLevel;
    logic                  oGameOver;
    logic                  oMoveStrobe;
    modport master (
        output iKEY_UP, iKEY_DOWN, iKEY_LEFT, iKEY_RIGHT, iPAUSE,
        input  oSEG_X, oSEG_Y, oLen, oLevel, oGameOver, oMoveStrobe
    );
    modport slave (
        input  iKEY_UP, iKEY_DOWN, iKEY_LEFT, iKEY_RIGHT, iPAUSE,
        output oSEG_X, oSEG_Y, oLen, oLevel, oGameOver, oMoveStrobe
    );
endinterface

// File: rtl/snake_motion_ctrl.sv
// snake_motion_ctrl: snake game-state engine (moves, collisions, growth, level) feeding the VGA renderer.
// Define SNAKE_WRAP_EN to make the head re-enter at the opposite wall instead of dying there.
module snake_motion_ctrl #(
    parameter int SEG_MAX  = 12,
    parameter int STEP     = 20,
    parameter int TICK_DIV = 2_500_000,
    parameter int X_MIN    = 20,
    parameter int X_MAX    = 600,
    parameter int Y_MIN    = 20,
    parameter int Y_MAX    = 440
) (
    input logic               iCLK,
    input logic               iRST,
    snake_motion_ctrl_if.slave bus
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [9:0] PARK = 10'h3FF;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;
    state_t        state_q, state_d;
    dir_t          dir_q, dir_d, pend_q, pend_d, req;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    len_q, len_d;
    logic [1:0]    level_q, level_d;
    logic          strobe_q, strobe_d;
    logic [9:0]    x_q [SEG_MAX];
    logic [9:0]    y_q [SEG_MAX];
    logic [9:0]    x_d [SEG_MAX];
    logic [9:0]    y_d [SEG_MAX];
    logic [9:0]    sx, sy, nx, ny, tgt_x, tgt_y;
    logic          any_key, move, wall_hit, self_hit, grow, step;
    always_comb begin
        any_key = bus.iKEY_UP | bus.iKEY_DOWN | bus.iKEY_LEFT | bus.iKEY_RIGHT;
        req = bus.iKEY_UP ? D_UP : bus.iKEY_DOWN ? D_DOWN : bus.iKEY_LEFT ? D_LEFT : D_RIGHT;
        move = state_q == S_RUN && !bus.iPAUSE && tick_q == TW'(TICK_DIV - 1);
        sx = pend_q == D_RIGHT ? x_q[0] + 10'(STEP) : pend_q == D_LEFT ? x_q[0] - 10'(STEP) : x_q[0];
        sy = pend_q == D_DOWN ? y_q[0] + 10'(STEP) : pend_q == D_UP ? y_q[0] - 10'(STEP) : y_q[0];
`ifdef SNAKE_WRAP_EN
        nx = sx > 10'(X_MAX) ? 10'(X_MIN) : sx < 10'(X_MIN) ? 10'(X_MAX) : sx;
        ny = sy > 10'(Y_MAX) ? 10'(Y_MIN) : sy < 10'(Y_MIN) ? 10'(Y_MAX) : sy;
        wall_hit = 1'b0;
`else
        nx = sx;
        ny = sy;
        wall_hit = sx < 10'(X_MIN) || sx > 10'(X_MAX) || sy < 10'(Y_MIN) || sy > 10'(Y_MAX);
`endif
        // The tail vacates on this move, so it is not an obstacle.
        self_hit = 1'b0;
        for (int j = 0; j < SEG_MAX; j++)
            if (j < int'(len_q) - 1 && x_q[j] == nx && y_q[j] == ny) self_hit = 1'b1;
        tgt_x = level_q == 2'd0 ? 10'd300 : 10'd160;
        tgt_y = level_q == 2'd0 ? 10'd200 : 10'd300;
        grow = level_q < 2'd2 && nx == tgt_x && ny == tgt_y;
        step = move && !wall_hit && !self_hit;
        state_d = state_q == S_IDLE && any_key ? S_RUN : move && !step ? S_OVER : state_q;
        tick_d = state_q == S_RUN && !bus.iPAUSE ? (move ? '0 : tick_q + TW'(1)) : tick_q;
        pend_d = state_q == S_RUN && any_key && (req ^ dir_q) != 2'b01 ? req : pend_q;
        dir_d = step ? pend_q : dir_q;
        strobe_d = step;
        level_d = step && grow ? level_q + 2'd1 : level_q;
        len_d = step && grow ? (len_q >= 4'(SEG_MAX - 4) ? 4'(SEG_MAX) : len_q + 4'd4) : len_q;
        x_d[0] = step ? nx : x_q[0];
        y_d[0] = step ? ny : y_q[0];
        // New segments stack on the old tail and unfold as the body shifts.
        for (int i = 1; i < SEG_MAX; i++) begin
            x_d[i] = !step ? x_q[i] : i < int'(len_q) ? x_q[i-1] :
                     grow && i < int'(len_q) + 4 ? x_q[len_q - 4'd1] : x_q[i];
            y_d[i] = !step ? y_q[i] : i < int'(len_q) ? y_q[i-1] :
                     grow && i < int'(len_q) + 4 ? y_q[len_q - 4'd1] : y_q[i];
        end
    end
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= S_IDLE;
            dir_q    <= D_RIGHT;
            pend_q   <= D_RIGHT;
            tick_q   <= '0;
            len_q    <= 4'd4;
            level_q  <= 2'd0;
            strobe_q <= 1'b0;
            for (int i = 0; i < SEG_MAX; i++) begin
                x_q[i] <= i < 4 ? 10'(320 - 20 * i) : PARK;
                y_q[i] <= i < 4 ? 10'd240 : PARK;
            end
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            len_q    <= len_d;
            level_q  <= level_d;
            strobe_q <= strobe_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end
    for (genvar g = 0; g < SEG_MAX; g++) begin : g_pack
        assign bus.oSEG_X[10*g +: 10] = x_q[g];
        assign bus.oSEG_Y[10*g +: 10] = y_q[g];
    end
    assign bus.oLen        = len_q;
    assign bus.oLevel      = level_q;
    assign bus.oGameOver   = state_q == S_OVER;
    assign bus.oMoveStrobe = strobe_q;
endmodule

// File: tb/tb_snake_motion_ctrl.sv
// tb_snake_motion_ctrl: directed scenarios plus piloted random play against a queue-based game model.
module tb_snake_motion_ctrl;
    localparam int SEG = 12;
    localparam int TD  = 4;
    typedef struct {int x; int y;} pt_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    pt_t  body[$];
    int   m_len, m_level, m_dir, m_pend, m_st, m_tick;
    bit   m_strobe;
    always #5 clk = ~clk;
    snake_motion_ctrl_if #(.SEG_MAX(SEG)) bus ();
    snake_motion_ctrl #(.SEG_MAX(SEG), .TICK_DIV(TD)) dut (.iCLK(clk), .iRST(rst), .bus(bus));
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask
    function automatic void model_reset();
        body.delete();
        for (int i = 0; i < 4; i++) body.push_back('{320 - 20 * i, 240});
        m_len = 4; m_level = 0; m_dir = 3; m_pend = 3; m_st = 0; m_tick = 0; m_strobe = 0;
    endfunction
    // Directions: 0 up, 1 down, 2 left, 3 right.
    function automatic void model_step(bit u, bit d, bit l, bit r, bit p);
        int  np, req, nx, ny;
        bit  coll, grow;
        pt_t tail;
        m_strobe = 0;
        if (m_st == 0) begin
            if (u | d | l | r) m_st = 1;
            return;
        end
        if (m_st == 2) return;
        np = m_pend;
        if (u | d | l | r) begin
            req = u ? 0 : d ? 1 : l ? 2 : 3;
            if (!(req / 2 == m_dir / 2 && req != m_dir)) np = req;
        end
        if (!p && m_tick == TD - 1) begin
            nx = (body[0].x + (m_pend == 3 ? 20 : m_pend == 2 ? -20 : 0)) & 1023;
            ny = (body[0].y + (m_pend == 1 ? 20 : m_pend == 0 ? -20 : 0)) & 1023;
            coll = nx < 20 || nx > 600 || ny < 20 || ny > 440;
`ifdef SNAKE_WRAP_EN
            coll = 0;
            if (nx > 600) nx = 20; else if (nx < 20) nx = 600;
            if (ny > 440) ny = 20; else if (ny < 20) ny = 440;
`endif
            for (int j = 0; j <= m_len - 2; j++)
                if (body[j].x == nx && body[j].y == ny) coll = 1;
            if (coll) m_st = 2;
            else begin
                grow = m_level < 2 && nx == (m_level == 0 ? 300 : 160) && ny == (m_level == 0 ? 200 : 300);
                tail = body[m_len - 1];
                body.push_front('{nx, ny});
                if (grow) begin
                    repeat (3) body.push_back(tail);
                    m_len = m_len + 4 > SEG ? SEG : m_len + 4;
                    m_level++;
                end else void'(body.pop_back());
                m_dir = m_pend;
                m_strobe = 1;
            end
        end
        if (!p) m_tick = (m_tick + 1) % TD;
        m_pend = np;
    endfunction
    task automatic compare_all();
        logic [10*SEG-1:0] ex, ey;
        for (int i = 0; i < SEG; i++) begin
            ex[10*i +: 10] = i < m_len ? 10'(body[i].x) : 10'h3FF;
            ey[10*i +: 10] = i < m_len ? 10'(body[i].y) : 10'h3FF;
        end
        check("seg_x", 128'(bus.oSEG_X), 128'(ex));
        check("seg_y", 128'(bus.oSEG_Y), 128'(ey));
        check("len", 128'(bus.oLen), 128'(m_len));
        check("level", 128'(bus.oLevel), 128'(m_level));
        check("game_over", 128'(bus.oGameOver), 128'(m_st == 2));
        check("strobe", 128'(bus.oMoveStrobe), 128'(m_strobe));
    endtask
    task automatic cyc(input logic [3:0] k, input bit p);
        bus.iKEY_UP = k[3]; bus.iKEY_DOWN = k[2]; bus.iKEY_LEFT = k[1]; bus.iKEY_RIGHT = k[0];
        bus.iPAUSE = p;
        model_step(k[3], k[2], k[1], k[0], p);
        @(negedge clk);
        compare_all();
    endtask
    task automatic do_reset();
        bus.iKEY_UP = 0; bus.iKEY_DOWN = 0; bus.iKEY_LEFT = 0; bus.iKEY_RIGHT = 0; bus.iPAUSE = 0;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_head_x", 128'(bus.oSEG_X[9:0]), 128'(320));
        check("rst_len", 128'(bus.oLen), 128'(4));
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask
    function automatic logic [3:0] pilot();
        int tx, ty, h, v;
        if (m_level >= 2) return 4'b1000 >> $urandom_range(0, 3);
        tx = m_level == 0 ? 300 : 160;
        ty = m_level == 0 ? 200 : 300;
        h = body[0].x < tx ? 3 : 2;
        v = body[0].y < ty ? 1 : 0;
        if (body[0].x != tx && !(h / 2 == m_dir / 2 && h != m_dir)) return 4'b1000 >> h;
        if (body[0].y != ty && !(v / 2 == m_dir / 2 && v != m_dir)) return 4'b1000 >> v;
        return m_dir < 2 ? 4'b0010 : 4'b1000;
    endfunction
    initial begin
        int over_cnt, r;
        logic [3:0] k;
        bus.iKEY_UP = 0; bus.iKEY_DOWN = 0; bus.iKEY_LEFT = 0; bus.iKEY_RIGHT = 0; bus.iPAUSE = 0;
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        cyc(4'b0001, 0);
        repeat (3) cyc(4'b0000, 0);
        check("pre_strobe", 128'(bus.oMoveStrobe), 128'(0));
        cyc(4'b0000, 0);
        check("first_strobe", 128'(bus.oMoveStrobe), 128'(1));
        check("first_head_x", 128'(bus.oSEG_X[9:0]), 128'(340));
        check("first_seg3_x", 128'(bus.oSEG_X[39:30]), 128'(280));
        cyc(4'b0010, 0);
        repeat (3) cyc(4'b0000, 0);
        check("left_ignored_x", 128'(bus.oSEG_X[9:0]), 128'(360));
        cyc(4'b1010, 0);
        repeat (3) cyc(4'b0000, 0);
        check("up_wins_y", 128'(bus.oSEG_Y[9:0]), 128'(220));
        repeat (10) cyc(4'b0000, 1);
        repeat (4) cyc(4'b0000, 0);
        check("resume_y", 128'(bus.oSEG_Y[9:0]), 128'(200));
        do_reset();
        cyc(4'b0001, 0);
        repeat (60) cyc(4'b0000, 0);
`ifdef SNAKE_WRAP_EN
        check("wall_wrap_x", 128'(bus.oSEG_X[9:0]), 128'(20));
        check("wall_wrap_run", 128'(bus.oGameOver), 128'(0));
`else
        check("wall_head_x", 128'(bus.oSEG_X[9:0]), 128'(600));
        check("wall_over", 128'(bus.oGameOver), 128'(1));
`endif
        repeat (4) cyc(4'b0000, 0);
        do_reset();
        cyc(4'b0001, 0);
        repeat (2) cyc(4'b0000, 0);
        do_reset();
        for (int ep = 0; ep < 25; ep++) begin
            do_reset();
            over_cnt = 0;
            for (int c = 0; c < 400 && over_cnt < 6; c++) begin
                r = $urandom_range(0, 99);
                k = r < 60 ? pilot() : r < 85 ? 4'b0000 : 4'($urandom_range(0, 15));
                cyc(k, $urandom_range(0, 9) == 0);
                if (m_st == 2) over_cnt++;
                if ($urandom_range(0, 299) == 0) do_reset();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
